// File: rtl/alu_issue_stage.sv
// alu_issue_stage: one-entry ID/EX buffer in front of the 64-bit ALU, with MEM/WB operand forwarding.
// Latency: an accepted instruction is presented on the ALU outputs the cycle after acceptance.
// Backpressure: holds while out_ready=0 or while a used source waits on a MEM load. in_ready=!valid_q||fire.
// Ports: clk/reset (async active-high); in_* decoded instruction with valid/ready; flush drops both
//        the held and the incoming instruction; mem_*/wb_* forwarding sources; out_valid/out_ready
//        handshake; alu_a/alu_b/alu_control/out_rd/out_store_data drive the ALU and EX/MEM.
module alu_issue_stage #(
    parameter int N     = 64,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_pc,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rd,
    input  logic [N-1:0]     in_rs1_val,
    input  logic [N-1:0]     in_rs2_val,
    input  logic [N-1:0]     in_imm,
    input  logic             in_use_pc,
    input  logic             in_use_imm,
    input  logic [3:0]       in_control,
    input  logic             flush,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [N-1:0]     mem_result,
    input  logic             mem_result_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [N-1:0]     wb_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_control,
    output logic [REG_W-1:0] out_rd,
    output logic [N-1:0]     out_store_data
);

    // Held entry
    logic             valid_q,   valid_d;
    logic [N-1:0]     pc_q,      pc_d;
    logic [REG_W-1:0] rs1_q,     rs1_d;
    logic [REG_W-1:0] rs2_q,     rs2_d;
    logic [REG_W-1:0] rd_q,      rd_d;
    logic [N-1:0]     rs1_val_q, rs1_val_d;
    logic [N-1:0]     rs2_val_q, rs2_val_d;
    logic [N-1:0]     imm_q,     imm_d;
    logic             use_pc_q,  use_pc_d;
    logic             use_imm_q, use_imm_d;
    logic [3:0]       control_q, control_d;

    // Forwarding
    logic             rs1_mem_hit, rs1_wb_hit, rs2_mem_hit, rs2_wb_hit;
    logic [N-1:0]     fwd_rs1, fwd_rs2;
    logic             rs1_refresh, rs2_refresh;
    logic             hazard;
    logic             fire, accept;

    always_comb begin
        // x0 never matches a producer, so its held value is always used
        rs1_mem_hit = (rs1_q != '0) && (rs1_q == mem_rd);
        rs1_wb_hit  = (rs1_q != '0) && (rs1_q == wb_rd);
        rs2_mem_hit = (rs2_q != '0) && (rs2_q == mem_rd);
        rs2_wb_hit  = (rs2_q != '0) && (rs2_q == wb_rd);

        // MEM is younger than WB, so it has priority
        fwd_rs1 = rs1_mem_hit ? mem_result : (rs1_wb_hit ? wb_result : rs1_val_q);
        fwd_rs2 = rs2_mem_hit ? mem_result : (rs2_wb_hit ? wb_result : rs2_val_q);

        // Refresh only from a final value; a pending MEM load shadows any WB match
        rs1_refresh = rs1_mem_hit ? mem_result_valid : rs1_wb_hit;
        rs2_refresh = rs2_mem_hit ? mem_result_valid : rs2_wb_hit;

        // rs2 is always treated as used (it may be store data), rs1 only when not replaced by PC
        hazard = (rs1_mem_hit && !mem_result_valid && !use_pc_q) ||
                 (rs2_mem_hit && !mem_result_valid);
    end

    assign out_valid      = valid_q && !hazard;
    assign fire           = out_valid && out_ready;
    assign in_ready       = !valid_q || fire;
    assign accept         = in_valid && in_ready;

    assign alu_a          = use_pc_q  ? pc_q  : fwd_rs1;
    assign alu_b          = use_imm_q ? imm_q : fwd_rs2;
    assign out_store_data = fwd_rs2;
    assign alu_control    = control_q;
    assign out_rd         = rd_q;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        use_pc_d  = use_pc_q;
        use_imm_d = use_imm_q;
        control_d = control_q;

        if (flush) begin
            // Drops the held entry and any instruction offered in the same cycle
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            pc_d      = in_pc;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            rd_d      = in_rd;
            rs1_val_d = in_rs1_val;
            rs2_val_d = in_rs2_val;
            imm_d     = in_imm;
            use_pc_d  = in_use_pc;
            use_imm_d = in_use_imm;
            control_d = in_control;
        end else if (fire) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Capture producer values before they retire past WB while we are held
            if (rs1_refresh) rs1_val_d = fwd_rs1;
            if (rs2_refresh) rs2_val_d = fwd_rs2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
            use_pc_q  <= 1'b0;
            use_imm_q <= 1'b0;
            control_q <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            use_pc_q  <= use_pc_d;
            use_imm_q <= use_imm_d;
            control_q <= control_d;
        end
    end

endmodule
